reset_sequencer: RTL and testbench

Ordered reset-release controller for the edge-detection pipeline. It takes the board-level asynchronous reset and releases N per-subsystem resets one at a time, for example: pixel input, line buffers, Sobel core, output writer. Each stage reset is asserted asynchronously and deasserted synchronously. Each stage is held for a programmable number of cycles and must report ready before the next stage is released. A software-requested re-sequence is supported with a req/ack handshake.

---
 rtl/reset_sequencer_if.sv | 31 +++
 rtl/reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Bundles the sequencer's control/status signals between the reset
//   sequencer and the subsystems/software it serves.
//   master : the sequencer (drives per-stage resets and status)
//   slave  : subsystems and software (drive ready flags and re-sequence request)
//   Signals: sw_reset_req, stage_ready[N_STAGES], stage_reset_n[N_STAGES],
//            seq_done, busy, sw_reset_ack, timeout_err, err_stage[IDX_W]
interface reset_sequencer_if #(
    parameter int N_STAGES = 4
);
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    logic                sw_reset_req;
    logic [N_STAGES-1:0] stage_ready;
    logic [N_STAGES-1:0] stage_reset_n;
    logic                seq_done;
    logic                busy;
    logic                sw_reset_ack;
    logic                timeout_err;
    logic [IDX_W-1:0]    err_stage;

    modport master (
        input  sw_reset_req, stage_ready,
        output stage_reset_n, seq_done, busy, sw_reset_ack, timeout_err, err_stage
    );

    modport slave (
        output sw_reset_req, stage_ready,
        input  stage_reset_n, seq_done, busy, sw_reset_ack, timeout_err, err_stage
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Releases N_STAGES subsystem resets one at a time after the board reset.
//   Each stage is held HOLD_CYCLES cycles, released, and must report ready
//   before the next stage starts its hold. A software re-sequence request
//   (req/ack) is accepted only in RUN.
// Ports
//   clk        : clock
//   a_reset_n  : asynchronous active-low board reset
//   seq_if     : reset_sequencer_if.master (ready/request in, resets/status out)
// Optional feature
//   RST_SEQ_WDT_EN : ready watchdog. When defined, a stage that does not report
//   ready within TIMEOUT_CYCLES edges of release sets the sticky timeout_err,
//   records err_stage and the sequence continues. When undefined, WAIT_RDY
//   waits forever and timeout_err/err_stage are tied to 0.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RST       | board reset active or not yet synchronised; all held
// ST_HOLD      | stage idx_q held in reset for HOLD_CYCLES cycles
// ST_WAIT_RDY  | stage idx_q released, waiting for its ready flag
// ST_RUN       | all stages released and ready
// ST_SW_ASSERT | software re-sequence: all stages held for HOLD_CYCLES
module reset_sequencer #(
    parameter int N_STAGES       = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 a_reset_n,
    reset_sequencer_if.master    seq_if
);
    localparam int IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    typedef enum logic [2:0] {
        ST_RST,
        ST_HOLD,
        ST_WAIT_RDY,
        ST_RUN,
        ST_SW_ASSERT
    } state_t;

    logic [1:0]          sync_q;
    logic                sync_rise;
    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sw_origin_q;
    logic [N_STAGES-1:0] stage_reset_n_q;
    logic                seq_done_q;
    logic                busy_q;
    logic                sw_reset_ack_q;
    logic                ready_sel;
    logic                wdt_expire;

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // The FSM leaves RST on the same edge that the synchroniser output goes
    // high, so the first hold period starts together with the synchronised
    // reset release rather than one cycle after it.
    assign sync_rise = sync_q[0] & ~sync_q[1];

    // Ready of unreleased stages never matters: only the stage under test
    // is looked at, and only while waiting for it.
    assign ready_sel = seq_if.stage_ready[idx_q];

`ifdef RST_SEQ_WDT_EN
    localparam logic [CNT_W-1:0] WDT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
    logic             timeout_err_q;
    logic [IDX_W-1:0] err_stage_q;

    assign wdt_expire = (cnt_q == WDT_TC);
`else
    assign wdt_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q         <= ST_RST;
            idx_q           <= '0;
            cnt_q           <= '0;
            sw_origin_q     <= 1'b0;
            stage_reset_n_q <= '0;
            seq_done_q      <= 1'b0;
            busy_q          <= 1'b1;
            sw_reset_ack_q  <= 1'b0;
`ifdef RST_SEQ_WDT_EN
            timeout_err_q   <= 1'b0;
            err_stage_q     <= '0;
`endif
        end else begin
            sw_reset_ack_q <= 1'b0;
            // Saturating counter; every state entry below reloads it to 0.
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_RST: begin
                    if (sync_rise) begin
                        state_q <= ST_HOLD;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_TC) begin
                        stage_reset_n_q[idx_q] <= 1'b1;
                        state_q                <= ST_WAIT_RDY;
                        cnt_q                  <= '0;
                    end
                end
                ST_WAIT_RDY: begin
                    if (ready_sel || wdt_expire) begin
`ifdef RST_SEQ_WDT_EN
                        if (!ready_sel) begin
                            timeout_err_q <= 1'b1;
                            err_stage_q   <= idx_q;
                        end
`endif
                        cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q    <= ST_RUN;
                            seq_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            if (sw_origin_q) begin
                                sw_reset_ack_q <= 1'b1;
                                sw_origin_q    <= 1'b0;
                            end
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_RUN: begin
                    if (seq_if.sw_reset_req) begin
                        state_q         <= ST_SW_ASSERT;
                        stage_reset_n_q <= '0;
                        seq_done_q      <= 1'b0;
                        busy_q          <= 1'b1;
                        sw_origin_q     <= 1'b1;
                        cnt_q           <= '0;
`ifdef RST_SEQ_WDT_EN
                        timeout_err_q   <= 1'b0;
                        err_stage_q     <= '0;
`endif
                    end
                end
                ST_SW_ASSERT: begin
                    if (cnt_q == HOLD_TC) begin
                        state_q <= ST_HOLD;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_RST;
                end
            endcase
        end
    end

    assign seq_if.stage_reset_n = stage_reset_n_q;
    assign seq_if.seq_done      = seq_done_q;
    assign seq_if.busy          = busy_q;
    assign seq_if.sw_reset_ack  = sw_reset_ack_q;
`ifdef RST_SEQ_WDT_EN
    assign seq_if.timeout_err   = timeout_err_q;
    assign seq_if.err_stage     = err_stage_q;
`else
    assign seq_if.timeout_err   = 1'b0;
    assign seq_if.err_stage     = '0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Scoreboarded bench for reset_sequencer with N_STAGES=3, HOLD_CYCLES=4,
//   TIMEOUT_CYCLES=8. Each scenario task pushes the expected output vector
//   for each clock edge; a monitor pops and compares at the matching edge.
//   Vector layout: {stage_reset_n[2:0], seq_done, busy, sw_reset_ack,
//                   timeout_err, err_stage[1:0]}
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic a_reset_n = 1'b0;
    int   ecnt = 0;
    int   base = 0;
    int   vectors = 0;
    int   misc = 0;

    typedef struct {
        string      name;
        int         at;
        logic [8:0] v;
    } exp_t;

    exp_t sbq[$];

    reset_sequencer_if #(.N_STAGES(3)) bus ();

    reset_sequencer #(
        .N_STAGES      (3),
        .HOLD_CYCLES   (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .a_reset_n(a_reset_n),
        .seq_if   (bus)
    );

    logic [8:0] obs;
    assign obs = {bus.stage_reset_n, bus.seq_done, bus.busy, bus.sw_reset_ack,
                  bus.timeout_err, bus.err_stage};

    localparam logic [8:0] RESET_VEC = 9'b000_0_1_0_0_00;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sbq.size() > 0 && sbq[0].at <= ecnt) begin
                e = sbq.pop_front();
                vectors++;
                if (e.at != ecnt || obs !== e.v) begin
                    misc++;
                    $display("FAIL %s edge %0d: got %b required %b", e.name, e.at - base, obs, e.v);
                end
            end
        end
    end

    function automatic void push(string n, int f, int t, logic [2:0] s, logic d, logic b,
                                 logic a, logic te, logic [1:0] es);
        for (int k = f; k <= t; k++) begin
            sbq.push_back('{n, base + k, {s, d, b, a, te, es}});
        end
    endfunction

    task automatic wait_until(input int k);
        while (ecnt < base + k) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget && sbq.size() > 0; n++) @(negedge clk);
        if (sbq.size() > 0) begin
            vectors++;
            misc++;
            $display("FAIL scoreboard_drain: %0d entries pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic reset_release(input logic [2:0] rdy, input logic sw);
        @(negedge clk);
        a_reset_n        = 1'b0;
        bus.stage_ready  = rdy;
        bus.sw_reset_req = sw;
        repeat (2) @(negedge clk);
        a_reset_n = 1'b1;
        base      = ecnt;
    endtask

    task automatic push_power_on(string n);
        push(n, 1, 5, 3'b000, 0, 1, 0, 0, 2'b00);
        push(n, 6, 10, 3'b001, 0, 1, 0, 0, 2'b00);
        push(n, 11, 15, 3'b011, 0, 1, 0, 0, 2'b00);
        push(n, 16, 16, 3'b111, 0, 1, 0, 0, 2'b00);
        push(n, 17, 20, 3'b111, 1, 0, 0, 0, 2'b00);
    endtask

    task automatic test_reset();
        bus.stage_ready  = 3'b111;
        bus.sw_reset_req = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== RESET_VEC) begin
            misc++;
            $display("FAIL reset_values: got %b required %b", obs, RESET_VEC);
        end
    endtask

    task automatic test_power_on();
        reset_release(3'b111, 1'b0);
        push_power_on("power_on");
        wait_drain(60);
    endtask

    task automatic test_ready_delay();
        reset_release(3'b101, 1'b0);
        push("ready_delay", 1, 5, 3'b000, 0, 1, 0, 0, 2'b00);
        push("ready_delay", 6, 10, 3'b001, 0, 1, 0, 0, 2'b00);
`ifdef RST_SEQ_WDT_EN
        push("ready_delay", 11, 18, 3'b011, 0, 1, 0, 0, 2'b00);
        push("ready_delay", 19, 22, 3'b011, 0, 1, 0, 1, 2'b01);
        push("ready_delay", 23, 23, 3'b111, 0, 1, 0, 1, 2'b01);
        push("ready_delay", 24, 39, 3'b111, 1, 0, 0, 1, 2'b01);
`else
        push("ready_delay", 11, 34, 3'b011, 0, 1, 0, 0, 2'b00);
        push("ready_delay", 35, 35, 3'b111, 0, 1, 0, 0, 2'b00);
        push("ready_delay", 36, 39, 3'b111, 1, 0, 0, 0, 2'b00);
`endif
        wait_until(30);
        bus.stage_ready = 3'b111;
        wait_drain(60);
    endtask

    // Continues from RUN reached in test_ready_delay.
    task automatic test_sw_pulse();
        push("sw_pulse", 41, 48, 3'b000, 0, 1, 0, 0, 2'b00);
        push("sw_pulse", 49, 53, 3'b001, 0, 1, 0, 0, 2'b00);
        push("sw_pulse", 54, 58, 3'b011, 0, 1, 0, 0, 2'b00);
        push("sw_pulse", 59, 59, 3'b111, 0, 1, 0, 0, 2'b00);
        push("sw_pulse", 60, 60, 3'b111, 1, 0, 1, 0, 2'b00);
        push("sw_pulse", 61, 64, 3'b111, 1, 0, 0, 0, 2'b00);
        wait_until(40);
        bus.sw_reset_req = 1'b1;
        wait_until(41);
        bus.sw_reset_req = 1'b0;
        wait_drain(60);
    endtask

    task automatic test_async_reset();
        reset_release(3'b111, 1'b0);
        push("async_pre", 1, 5, 3'b000, 0, 1, 0, 0, 2'b00);
        push("async_pre", 6, 8, 3'b001, 0, 1, 0, 0, 2'b00);
        wait_until(8);
        a_reset_n = 1'b0;
        #1;
        vectors++;
        if (obs !== RESET_VEC) begin
            misc++;
            $display("FAIL async_assert: got %b required %b", obs, RESET_VEC);
        end
        @(negedge clk);
        vectors++;
        if (obs !== RESET_VEC) begin
            misc++;
            $display("FAIL async_held: got %b required %b", obs, RESET_VEC);
        end
        @(negedge clk);
        a_reset_n = 1'b1;
        base      = ecnt;
        push_power_on("async_restart");
        wait_drain(60);
    endtask

    task automatic test_sw_held();
        reset_release(3'b111, 1'b1);
        push("sw_held", 1, 5, 3'b000, 0, 1, 0, 0, 2'b00);
        push("sw_held", 6, 10, 3'b001, 0, 1, 0, 0, 2'b00);
        push("sw_held", 11, 15, 3'b011, 0, 1, 0, 0, 2'b00);
        push("sw_held", 16, 16, 3'b111, 0, 1, 0, 0, 2'b00);
        push("sw_held", 17, 17, 3'b111, 1, 0, 0, 0, 2'b00);
        push("sw_held", 18, 25, 3'b000, 0, 1, 0, 0, 2'b00);
        push("sw_held", 26, 30, 3'b001, 0, 1, 0, 0, 2'b00);
        push("sw_held", 31, 35, 3'b011, 0, 1, 0, 0, 2'b00);
        push("sw_held", 36, 36, 3'b111, 0, 1, 0, 0, 2'b00);
        push("sw_held", 37, 37, 3'b111, 1, 0, 1, 0, 2'b00);
        push("sw_held", 38, 40, 3'b111, 1, 0, 0, 0, 2'b00);
        wait_until(18);
        bus.sw_reset_req = 1'b0;
        wait_drain(60);
    endtask

    task automatic test_stuck_ready();
        reset_release(3'b101, 1'b0);
        push("stuck_ready", 1, 5, 3'b000, 0, 1, 0, 0, 2'b00);
        push("stuck_ready", 6, 10, 3'b001, 0, 1, 0, 0, 2'b00);
`ifdef RST_SEQ_WDT_EN
        push("stuck_ready", 11, 18, 3'b011, 0, 1, 0, 0, 2'b00);
        push("stuck_ready", 19, 22, 3'b011, 0, 1, 0, 1, 2'b01);
        push("stuck_ready", 23, 23, 3'b111, 0, 1, 0, 1, 2'b01);
        push("stuck_ready", 24, 29, 3'b111, 1, 0, 0, 1, 2'b01);
        push("stuck_ready", 30, 33, 3'b000, 0, 1, 0, 0, 2'b00);
        wait_until(29);
        bus.sw_reset_req = 1'b1;
        wait_until(30);
        bus.sw_reset_req = 1'b0;
`else
        push("stuck_ready", 11, 40, 3'b011, 0, 1, 0, 0, 2'b00);
`endif
        wait_drain(60);
    endtask

    initial begin : guard
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        bus.stage_ready  = 3'b000;
        bus.sw_reset_req = 1'b0;
        test_reset();
        test_power_on();
        test_ready_delay();
        test_sw_pulse();
        test_async_reset();
        test_sw_held();
        test_stuck_ready();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
